concat_sched: RTL and testbench
===============================

# concat_sched

Sequencer that merges two time-aligned channel streams, left (`data_li`) and right (`data_ri`), into one output stream ahead of the max-pool stage. Each pixel arrives as a burst of up to `BURST` beats on both inputs at once. The block forwards the left beats immediately, buffers the right beats, and then drains them back-to-back behind the left burst. It also re-times the line and frame markers onto the merged stream and rejects bursts that violate the input spacing contract.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of each data beat.
- `BURST`, 16, maximum beats per pixel per side; also the right-buffer depth (power of 2, ≥2).

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `data_valid_i`  in  1  left and right beats valid this cycle.
- `data_li`  in  `DATA_WIDTH` signed  left channel beat.
- `data_ri`  in  `DATA_WIDTH` signed  right channel beat.
- `sop_i`, `sof_i`  in  1 each  qualify the first beat of a line / frame.
- `eop_i`, `eof_i`  in  1 each  qualify the last beat of a line / frame.
- `data_o`  out  `DATA_WIDTH` signed  merged beat.
- `data_valid_o`  out  1  merged beat valid.
- `sop_o`, `eop_o`, `sof_o`, `eof_o`  out  1 each  markers on the merged stream.
- `busy_o`  out  1  high when the state is not IDLE.
- `err_o`  out  1  sticky contract violation; present only with the macro.

## Operation
- There is no backpressure. The source guarantees at least n idle cycles after an n-beat burst.
- FSM states are IDLE, PASS_L, DRAIN_R and SKIP.
- IDLE:
  - `data_valid_i`=1 goes to PASS_L. The beat is forwarded and `data_ri` is written to the buffer.
  - The beat counter is set to 1.
- PASS_L:
  - Each valid beat forwards `data_li`, writes `data_ri` and increments the counter.
  - `data_valid_i`=0 latches n = counter and goes to DRAIN_R.
  - If the counter reaches `BURST` on a valid beat, n = `BURST` is latched and the state goes to DRAIN_R on the next cycle.
- DRAIN_R:
  - Reads the n buffered beats in write order. The buffer has a 1-cycle read latency; reads are issued so the beats come out contiguously.
  - Returns to IDLE after the last read data is output.
- Violation: any `data_valid_i` in DRAIN_R. This covers an early next burst and a beat beyond `BURST`.
  - The drain of the current burst completes unaffected.
  - The state then goes to SKIP if `data_valid_i` is still high, otherwise to IDLE.
- SKIP:
  - Discards beats: nothing is forwarded or written.
  - Returns to IDLE on the first cycle with `data_valid_i`=0.
- Markers:
  - `sop_i`/`sof_i` on beat 0 are latched and drive `sop_o`/`sof_o` on the first left output beat.
  - `eop_i`/`eof_i` on any accepted beat are latched as pending and drive `eop_o`/`eof_o` on the last right output beat, then clear.
  - Markers on discarded beats are dropped.
- Buffer pointers are `$clog2(BURST)` bits and wrap. Both pointers are equal at every IDLE entry.
- Reset, including mid-burst, clears the FSM, counters, pointers, pending markers and `err_o`. All outputs are 0 during reset; `data_o` is 0.

## Timing
- Burst of n beats with `data_valid_i` high in cycles 0..n-1:
  - left beat k is on `data_o` in cycle k+1;
  - right beat k is on `data_o` in cycle n+1+k;
  - `data_valid_o` is high in cycles 1..2n continuously.
- The next burst may start at cycle 2n at the earliest. A valid beat in cycles n+1..2n-1 is a violation.
  - For n<`BURST`, a valid beat at cycle n is a continuation.
  - For n=`BURST`, a valid beat at cycle n is a violation.
- `busy_o` is high in cycles 1..2n.

## Configuration
- `CONCAT_SCHED_ERR_EN` defined:
  - `err_o` exists;
  - it is set the cycle after a violation;
  - it is cleared only by reset.
- Undefined: `err_o` and its logic are absent. Violation handling (SKIP) is identical either way.

## Structure
- Shared package `concat_pkg`:
  - state enum `concat_state_t` (IDLE, PASS_L, DRAIN_R, SKIP);
  - default `BURST` and `DATA_WIDTH` localparams.
- One sub-module, `concat_buf`:
  - a `BURST`-deep synchronous FIFO with a registered read port;
  - write/read enables, asynchronous active-low reset on the pointers.
- The FSM, counters and marker latches live in `concat_sched`.

## Test plan
- Single 16-beat burst, left 1..16, right 101..116:
  - `data_o` = 1..16 in cycles 1..16, then 101..116 in cycles 17..32;
  - `data_valid_o` high for 32 cycles;
  - `sop_o` in cycle 1, `eop_o` in cycle 32.
- 5-beat short burst, left 1..5, right 11..15:
  - output 1..5 then 11..15 in cycles 1..10;
  - IDLE in cycle 11.
- Back-to-back 16-beat bursts with exactly 16 idle cycles between them: the output is continuous, 64 beats with no gap and no loss.
- Second burst starts 4 cycles after the first ends:
  - the first burst drains intact;
  - the second burst produces no output;
  - `err_o`=1 with the macro.
- `sof_i`+`sop_i` on beat 0 and `eof_i`+`eop_i` on beat 15: `sof_o`/`sop_o` in cycle 1, `eof_o`/`eop_o` in cycle 32.
- Assert `reset_n` in cycle 20 of a 16-beat burst:
  - all outputs 0 immediately;
  - after release, a fresh 3-beat burst outputs exactly 6 correct beats.

Source files
------------

// File: rtl/concat_sched_pkg.sv
// Shared types and defaults for the concat_sched channel merger.
package concat_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PASS_L  = 2'd1,
    DRAIN_R = 2'd2,
    SKIP    = 2'd3
  } concat_state_t;

endpackage

// File: rtl/concat_sched_buf.sv
// Right-channel buffer: DEPTH-deep synchronous FIFO with a registered read port.
module concat_buf
  import concat_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_BURST
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_en,
  input  logic signed [DATA_WIDTH-1:0] i_wr_data,
  input  logic                         i_rd_en,
  output logic signed [DATA_WIDTH-1:0] o_rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic        [AW-1:0]         r_wr_ptr;
  logic        [AW-1:0]         r_rd_ptr;
  logic signed [DATA_WIDTH-1:0] r_rd_data;

  // Storage array write
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Wrapping pointers and read register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (i_rd_en) begin
        r_rd_ptr  <= r_rd_ptr + PTR_ONE;
        r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/concat_sched.sv
// Merges left/right bursts into one stream: left passes through, right drains behind it.
// Optional sticky violation output err_o is built when CONCAT_SCHED_ERR_EN is defined.
module concat_sched
  import concat_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST      = DEF_BURST
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         data_valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_li,
  input  logic signed [DATA_WIDTH-1:0] data_ri,
  input  logic                         sop_i,
  input  logic                         sof_i,
  input  logic                         eop_i,
  input  logic                         eof_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o,
  output logic                         sop_o,
  output logic                         eop_o,
  output logic                         sof_o,
  output logic                         eof_o,
  output logic                         busy_o
`ifdef CONCAT_SCHED_ERR_EN
  ,
  output logic                         err_o
`endif
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_BURST = CW'(BURST);

  concat_state_t                r_state;
  logic        [CW-1:0]         r_cnt;
  logic        [CW-1:0]         r_n;
  logic        [CW-1:0]         r_rd_cnt;
  logic                         r_viol;
  logic signed [DATA_WIDTH-1:0] r_dout_l;
  logic                         r_rd_sel;
  logic                         r_valid_o;
  logic                         r_sop_o;
  logic                         r_sof_o;
  logic                         r_eop_o;
  logic                         r_eof_o;
  logic                         r_eop_pend;
  logic                         r_eof_pend;

  logic                         w_accept;
  logic                         w_start;
  logic                         w_rd_en;
  logic                         w_final;
  logic                         w_viol;
  logic                         w_last_rd;
  logic        [CW-1:0]         w_n_eff;
  logic signed [DATA_WIDTH-1:0] w_rd_data;

  concat_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BURST)
  ) u_buf (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .i_wr_en   (w_accept),
    .i_wr_data (data_ri),
    .i_rd_en   (w_rd_en),
    .o_rd_data (w_rd_data)
  );

  // Per-state accept/read decode; the final drain cycle doubles as an IDLE slot
  always_comb begin
    w_accept = 1'b0;
    w_start  = 1'b0;
    w_rd_en  = 1'b0;
    w_final  = 1'b0;
    w_viol   = 1'b0;
    w_n_eff  = r_n;
    case (r_state)
      IDLE: begin
        w_start  = data_valid_i;
        w_accept = data_valid_i;
      end
      PASS_L: begin
        w_accept = data_valid_i;
        w_rd_en  = ~data_valid_i;
        w_n_eff  = r_cnt;
      end
      DRAIN_R: begin
        if (r_rd_cnt != r_n) begin
          w_rd_en = 1'b1;
          w_viol  = data_valid_i;
        end else begin
          w_final  = 1'b1;
          w_start  = data_valid_i & ~r_viol;
          w_accept = data_valid_i & ~r_viol;
        end
      end
      SKIP: begin
        w_accept = 1'b0;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
    w_last_rd = w_rd_en & ((r_rd_cnt + C_ONE) == w_n_eff);
  end

  // Sequencer FSM with registered stream outputs and marker latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_n        <= '0;
      r_rd_cnt   <= '0;
      r_viol     <= 1'b0;
      r_dout_l   <= '0;
      r_rd_sel   <= 1'b0;
      r_valid_o  <= 1'b0;
      r_sop_o    <= 1'b0;
      r_sof_o    <= 1'b0;
      r_eop_o    <= 1'b0;
      r_eof_o    <= 1'b0;
      r_eop_pend <= 1'b0;
      r_eof_pend <= 1'b0;
    end else begin
      r_dout_l  <= w_accept ? data_li : '0;
      r_rd_sel  <= w_rd_en;
      r_valid_o <= w_accept | w_rd_en;
      r_sop_o   <= w_start & sop_i;
      r_sof_o   <= w_start & sof_i;
      r_eop_o   <= w_last_rd & r_eop_pend;
      r_eof_o   <= w_last_rd & r_eof_pend;
      if (w_accept && eop_i) begin
        r_eop_pend <= 1'b1;
      end else if (w_last_rd) begin
        r_eop_pend <= 1'b0;
      end
      if (w_accept && eof_i) begin
        r_eof_pend <= 1'b1;
      end else if (w_last_rd) begin
        r_eof_pend <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= PASS_L;
            r_cnt    <= C_ONE;
            r_rd_cnt <= '0;
            r_viol   <= 1'b0;
          end
        end
        PASS_L: begin
          if (data_valid_i) begin
            r_cnt <= r_cnt + C_ONE;
            if ((r_cnt + C_ONE) == C_BURST) begin
              r_n     <= C_BURST;
              r_state <= DRAIN_R;
            end
          end else begin
            r_n      <= r_cnt;
            r_rd_cnt <= C_ONE;
            r_state  <= DRAIN_R;
          end
        end
        DRAIN_R: begin
          if (!w_final) begin
            r_rd_cnt <= r_rd_cnt + C_ONE;
            if (w_viol) begin
              r_viol <= 1'b1;
            end
          end else if (w_start) begin
            r_state  <= PASS_L;
            r_cnt    <= C_ONE;
            r_rd_cnt <= '0;
            r_viol   <= 1'b0;
          end else if (data_valid_i) begin
            r_state <= SKIP;
          end else begin
            r_state <= IDLE;
          end
        end
        SKIP: begin
          if (!data_valid_i) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef CONCAT_SCHED_ERR_EN
  logic r_err;

  // Sticky contract-violation flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_viol) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

  assign data_o       = r_rd_sel ? w_rd_data : r_dout_l;
  assign data_valid_o = r_valid_o;
  assign sop_o        = r_sop_o;
  assign sof_o        = r_sof_o;
  assign eop_o        = r_eop_o;
  assign eof_o        = r_eof_o;
  assign busy_o       = (r_state != IDLE);

endmodule

// File: tb/tb_concat_sched.sv
// Directed self-checking bench for concat_sched (err_o checked when CONCAT_SCHED_ERR_EN is set).
module tb_concat_sched;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              data_valid_i = 1'b0;
  logic signed [7:0] data_li = 8'sd0;
  logic signed [7:0] data_ri = 8'sd0;
  logic              sop_i = 1'b0;
  logic              sof_i = 1'b0;
  logic              eop_i = 1'b0;
  logic              eof_i = 1'b0;
  logic signed [7:0] data_o;
  logic              data_valid_o;
  logic              sop_o;
  logic              eop_o;
  logic              sof_o;
  logic              eof_o;
  logic              busy_o;
`ifdef CONCAT_SCHED_ERR_EN
  logic              err_o;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  concat_sched #(
    .DATA_WIDTH (8),
    .BURST      (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_valid_i (data_valid_i),
    .data_li      (data_li),
    .data_ri      (data_ri),
    .sop_i        (sop_i),
    .sof_i        (sof_i),
    .eop_i        (eop_i),
    .eof_i        (eof_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .sop_o        (sop_o),
    .eop_o        (eop_o),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .busy_o       (busy_o)
`ifdef CONCAT_SCHED_ERR_EN
    ,
    .err_o        (err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [7:0] l, input logic signed [7:0] r,
                       input logic first, input logic last);
    data_valid_i = v;
    data_li      = l;
    data_ri      = r;
    sop_i        = first;
    sof_i        = first;
    eop_i        = last;
    eof_i        = last;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(data_o), 32'd0);
    chk({tag, "_valid"}, 32'(data_valid_o), 32'd0);
    chk({tag, "_sop"},   32'(sop_o), 32'd0);
    chk({tag, "_eop"},   32'(eop_o), 32'd0);
    chk({tag, "_sof"},   32'(sof_o), 32'd0);
    chk({tag, "_eof"},   32'(eof_o), 32'd0);
    chk({tag, "_busy"},  32'(busy_o), 32'd0);
`ifdef CONCAT_SCHED_ERR_EN
    chk({tag, "_err"},   32'(err_o), 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 8'sd0, 8'sd0, 1'b0, 1'b0);
    tick();
    tick();
    cyc = -1;
    chk_all_zero("rst");
    reset_n = 1'b1;
    tick();
  endtask

  // Burst A at s0 (n0 beats); optional burst B at s1 (n1 beats), rejected when skip1.
  task automatic run(input string tag, input int ncyc,
                     input int s0, input int n0, input int la, input int ra,
                     input int s1, input int n1, input int lb, input int rb, input bit skip1);
    int ev, ed, esop, eeop, ebusy, eerr, bend;
    for (int c = 0; c < ncyc; c++) begin
      cyc   = c;
      ev    = 0;
      ed    = 0;
      esop  = 0;
      eeop  = 0;
      ebusy = 0;
      eerr  = 0;
      if (c >= s0 + 1 && c <= s0 + n0) begin
        ev = 1; ed = la + c - s0 - 1; esop = (c == s0 + 1) ? 1 : 0;
      end
      if (c >= s0 + n0 + 1 && c <= s0 + 2 * n0) begin
        ev = 1; ed = ra + c - s0 - n0 - 1; eeop = (c == s0 + 2 * n0) ? 1 : 0;
      end
      if (c >= s0 + 1 && c <= s0 + 2 * n0) ebusy = 1;
      if (n1 > 0 && !skip1) begin
        if (c >= s1 + 1 && c <= s1 + n1) begin
          ev = 1; ed = lb + c - s1 - 1; esop = (c == s1 + 1) ? 1 : 0;
        end
        if (c >= s1 + n1 + 1 && c <= s1 + 2 * n1) begin
          ev = 1; ed = rb + c - s1 - n1 - 1; eeop = (c == s1 + 2 * n1) ? 1 : 0;
        end
        if (c >= s1 + 1 && c <= s1 + 2 * n1) ebusy = 1;
      end
      if (n1 > 0 && skip1) begin
        bend = (s1 + n1 - 1 >= s0 + 2 * n0) ? s1 + n1 : s0 + 2 * n0;
        if (c >= s0 + 1 && c <= bend) ebusy = 1;
        eerr = (c >= s1 + 1) ? 1 : 0;
      end
      chk({tag, "_valid"}, 32'(data_valid_o), ev);
      if (ev != 0) chk({tag, "_data"}, 32'(data_o), ed);
      chk({tag, "_sop"},  32'(sop_o), esop);
      chk({tag, "_sof"},  32'(sof_o), esop);
      chk({tag, "_eop"},  32'(eop_o), eeop);
      chk({tag, "_eof"},  32'(eof_o), eeop);
      chk({tag, "_busy"}, 32'(busy_o), ebusy);
`ifdef CONCAT_SCHED_ERR_EN
      chk({tag, "_err"},  32'(err_o), eerr);
`endif
      if (c >= s0 && c < s0 + n0)
        drive(1'b1, 8'(la + c - s0), 8'(ra + c - s0), c == s0, c == s0 + n0 - 1);
      else if (n1 > 0 && c >= s1 && c < s1 + n1)
        drive(1'b1, 8'(lb + c - s1), 8'(rb + c - s1), c == s1, c == s1 + n1 - 1);
      else
        drive(1'b0, 8'sd0, 8'sd0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    // Full 16-beat burst with frame/line markers
    do_reset();
    run("full16", 35, 0, 16, 1, 101, 0, 0, 0, 0, 1'b0);
    // Short burst, IDLE again at cycle 11
    do_reset();
    run("short5", 13, 0, 5, 1, 11, 0, 0, 0, 0, 1'b0);
    // Single-beat burst
    do_reset();
    run("one", 5, 0, 1, 7, 9, 0, 0, 0, 0, 1'b0);
    // Back-to-back bursts at the earliest legal spacing
    do_reset();
    run("b2b", 67, 0, 16, 1, 101, 32, 16, 41, 71, 1'b0);
    // Early second burst overlapping the drain and the final drain cycle
    do_reset();
    run("early", 40, 0, 16, 1, 101, 20, 16, 41, 71, 1'b1);
    // Beat right after a full BURST (cycle n) is a violation
    do_reset();
    run("over", 36, 0, 16, 1, 101, 16, 2, 41, 71, 1'b1);
    // Reset in cycle 20 of a 16-beat burst, then a fresh 3-beat burst
    do_reset();
    run("pre_rst", 20, 0, 16, 1, 101, 0, 0, 0, 0, 1'b0);
    cyc = 20;
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    run("post_rst", 9, 0, 3, 21, 31, 0, 0, 0, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
